// File: rtl/noise_pkg.sv
// noise_pkg: shared widths, FSM state type and the offset-binary conversion used by the
// noise readout drain stage (noise_readout, noise_skid2, noise_readout_if).
package noise_pkg;

  localparam int unsigned ACQ_W   = 12;  // ADC sample width, matches acquisition FIFO
  localparam int unsigned CNT_W   = 12;  // sample-count width, matches acquisition count
  localparam int unsigned DOUT_W  = 16;  // sign-extended output sample width
  localparam int unsigned SUM_W   = 24;  // signed record sum
  localparam int unsigned SUMSQ_W = 34;  // unsigned record sum of squares

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  // Offset-binary to two's complement: flip the MSB, then sign-extend to DOUT_W.
  function automatic logic [DOUT_W-1:0] ob2tc(input logic [ACQ_W-1:0] d);
    logic [ACQ_W-1:0] s;
    s = {~d[ACQ_W-1], d[ACQ_W-2:0]};
    return {{(DOUT_W - ACQ_W){s[ACQ_W-1]}}, s};
  endfunction

endpackage

// File: rtl/noise_readout_if.sv
// noise_readout_if: sample stream towards the DSP.
//   dout        converted sample, two's complement
//   dout_valid  dout holds a sample
//   dout_ready  consumer accepts dout when valid && ready
// master = producer (noise_readout), slave = DSP consumer.
interface noise_readout_if;
  import noise_pkg::*;

  logic [DOUT_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/noise_skid2.sv
// noise_skid2: 2-entry sample buffer between the FIFO read return and the DSP stream.
// Ports:
//   clk_sys, reset   clock, asynchronous active-high reset
//   push, push_data  write one converted sample
//   dout, dout_valid head entry and its valid flag (registered)
//   dout_ready       consumer ready; pop = dout_valid && dout_ready
//   occupancy        number of stored entries (0..2)
// The producer guarantees no push into a full buffer unless a pop happens in the same cycle.
module noise_skid2
  import noise_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              push,
  input  logic [DOUT_W-1:0] push_data,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [1:0]        occupancy
);

  logic [DOUT_W-1:0] buf0_q;  // head, drives dout directly
  logic [DOUT_W-1:0] buf1_q;
  logic [1:0]        occ_q;
  logic              pop;

  assign pop        = (occ_q != 2'd0) && dout_ready;
  assign dout       = buf0_q;
  assign dout_valid = (occ_q != 2'd0);
  assign occupancy  = occ_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      buf0_q <= '0;
      buf1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) buf0_q <= push_data;
          else               buf1_q <= push_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          buf0_q <= buf1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; shift when the second entry is live.
          if (occ_q == 2'd1) begin
            buf0_q <= push_data;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/noise_readout.sv
// noise_readout: drains one captured record from the acquisition FIFO (1-cycle read latency),
// converts each offset-binary sample to signed 16 bits and streams it to the DSP side, while
// accumulating the record sum (and, with NOISE_SUMSQ_EN defined, the sum of squares).
// Ports:
//   clk_sys, reset   clock, asynchronous active-high reset
//   start, acqnum    one-cycle start pulse and record length (sampled on start)
//   n_rd_en          FIFO read strobe; n_dataout valid the following cycle
//   n_dataout        FIFO read data, offset-binary
//   dsp              sample stream (noise_readout_if.master)
//   sum              signed sum of converted samples
//   sumsq            unsigned sum of squares (only with NOISE_SUMSQ_EN)
//   busy, done       record in progress / one-cycle completion pulse
// Config macro: NOISE_SUMSQ_EN adds the squarer, 34-bit accumulator and the sumsq port.
module noise_readout
  import noise_pkg::*;
(
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   acqnum,
  output logic               n_rd_en,
  input  logic [ACQ_W-1:0]   n_dataout,
  noise_readout_if.master    dsp,
  output logic [SUM_W-1:0]   sum,
`ifdef NOISE_SUMSQ_EN
  output logic [SUMSQ_W-1:0] sumsq,
`endif
  output logic               busy,
  output logic               done
);

  state_e             state_q;
  logic [CNT_W-1:0]   remaining_q;
  logic               inflight_q;  // a read was issued last cycle; n_dataout is valid now
  logic [SUM_W-1:0]   sum_q;
  logic               busy_q;
  logic               done_q;

  logic [1:0]         occ;
  logic               pop;
  logic [2:0]         credit_use;
  logic               rd_en;
  logic [DOUT_W-1:0]  samp;

  assign samp = ob2tc(n_dataout);
  assign pop  = dsp.dout_valid && dsp.dout_ready;

  // Entries the buffer will hold once the in-flight read lands and this cycle's pop retires.
  assign credit_use = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en      = (state_q == READ) && (remaining_q != '0) && (credit_use < 3'd2);

  assign n_rd_en = rd_en;
  assign sum     = sum_q;
  assign busy    = busy_q;
  assign done    = done_q;

  noise_skid2 u_skid (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .push       (inflight_q),
    .push_data  (samp),
    .dout       (dsp.dout),
    .dout_valid (dsp.dout_valid),
    .dout_ready (dsp.dout_ready),
    .occupancy  (occ)
  );

`ifdef NOISE_SUMSQ_EN
  logic [SUMSQ_W-1:0]        sumsq_q;
  logic signed [ACQ_W-1:0]   s12;
  logic signed [2*ACQ_W-1:0] sq;

  assign s12   = samp[ACQ_W-1:0];
  assign sq    = s12 * s12;  // always non-negative, at most 2^22
  assign sumsq = sumsq_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sumsq_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      sumsq_q <= '0;
    end else if (inflight_q) begin
      sumsq_q <= sumsq_q + {{(SUMSQ_W - 2*ACQ_W){1'b0}}, sq};
    end
  end
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      sum_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      done_q     <= 1'b0;
      if (rd_en) remaining_q <= remaining_q - 1'b1;
      // Accumulate as each sample enters the buffer, independent of the DSP handshake.
      if (inflight_q) sum_q <= sum_q + {{(SUM_W - DOUT_W){samp[DOUT_W-1]}}, samp};

      case (state_q)
        IDLE: begin
          if (start) begin
            remaining_q <= acqnum;
            sum_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= (acqnum == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (rd_en && (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1})) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!inflight_q && (occ == 2'd0)) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noise_readout.sv
// Self-checking bench for noise_readout: randomised records, a FIFO model feeding n_dataout,
// and a scoreboard queue of expected samples popped by an independent stream monitor.
module tb_noise_readout;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] acqnum;
  logic        n_rd_en;
  logic [11:0] n_dataout = 12'h000;
  logic [23:0] sum;
  logic [33:0] sumsq;
  logic        busy;
  logic        done;

  noise_readout_if dsp ();

  noise_readout dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .start     (start),
    .acqnum    (acqnum),
    .n_rd_en   (n_rd_en),
    .n_dataout (n_dataout),
    .dsp       (dsp.master),
    .sum       (sum),
`ifdef NOISE_SUMSQ_EN
    .sumsq     (sumsq),
`endif
    .busy      (busy),
    .done      (done)
  );

`ifndef NOISE_SUMSQ_EN
  assign sumsq = '0;
`endif

  always #5 clk_sys = ~clk_sys;

  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] mem [4096];
  int          rec_len = 0;
  int          rd_idx = 0;
  int          reads = 0;
  int          accepts = 0;
  logic        fifo_clear = 1'b0;
  int          ready_mode = 0;  // 0 = high, 1 = toggle, 2 = random
  logic [15:0] exp_q [$];
  longint      exp_sum;
  longint      exp_sumsq;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Acquisition FIFO model: data appears on n_dataout the cycle after n_rd_en.
  always @(posedge clk_sys) begin
    if (fifo_clear) begin
      rd_idx <= 0;
      reads  <= 0;
    end else if (n_rd_en) begin
      n_dataout <= (rd_idx < rec_len) ? mem[rd_idx] : 12'h000;
      rd_idx    <= rd_idx + 1;
      reads     <= reads + 1;
    end
  end

  // DSP-side ready driver.
  initial begin
    dsp.dout_ready = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      case (ready_mode)
        0:       dsp.dout_ready = 1'b1;
        1:       dsp.dout_ready = ~dsp.dout_ready;
        default: dsp.dout_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream monitor: scoreboard pops, stall stability, outstanding-entry bound.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_dout;
    logic [15:0] e;
    prev_stall = 1'b0;
    prev_dout  = '0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (fifo_clear) accepts = 0;
      if (busy) begin
        vectors++;
        if (reads - accepts > 2) begin
          miscompares++;
          $display("FAIL outstanding: got %0d entries, limit 2", reads - accepts);
        end
      end
      if (prev_stall) begin
        vectors++;
        if (!dsp.dout_valid || dsp.dout !== prev_dout) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%0b dout=%h, expected valid=1 dout=%h",
                   dsp.dout_valid, dsp.dout, prev_dout);
        end
      end
      if (dsp.dout_valid && dsp.dout_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_sample: got dout=%h, expected no sample", dsp.dout);
        end else begin
          e = exp_q.pop_front();
          if (dsp.dout !== e) begin
            miscompares++;
            $display("FAIL dout: got %h, expected %h", dsp.dout, e);
          end
        end
        accepts++;
      end
      prev_stall = dsp.dout_valid && !dsp.dout_ready;
      prev_dout  = dsp.dout;
    end
  end

  // Fill the FIFO image and push the expected stream; kind 0 fixed, 1 all 0xFFF, 2 random.
  task automatic load_record(input int n, input int kind);
    logic [11:0] fixed [4];
    int          s;
    fixed[0] = 12'h800; fixed[1] = 12'hFFF; fixed[2] = 12'h000; fixed[3] = 12'h801;
    exp_sum   = 0;
    exp_sumsq = 0;
    rec_len   = n;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       mem[i] = fixed[i % 4];
        1:       mem[i] = 12'hFFF;
        default: mem[i] = 12'($urandom_range(0, 4095));
      endcase
      s = int'(mem[i]) - 2048;
      exp_sum   += s;
      exp_sumsq += longint'(s) * longint'(s);
      exp_q.push_back(16'(s));
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk_sys);
    #1;
    start      = 1'b1;
    acqnum     = 12'(n);
    fifo_clear = 1'b1;
    @(posedge clk_sys);
    #1;
    start      = 1'b0;
    fifo_clear = 1'b0;
  endtask

  task automatic run_record(input string tag, input int n, input int kind, input int mode,
                            input bit mid);
    int cyc;
    int budget;
    logic [23:0] s24;
    load_record(n, kind);
    ready_mode = mode;
    pulse_start(n);
    cyc = 1;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_first_rd_en"}, n_rd_en, (n != 0));
    if (n > 0) begin
      @(posedge clk_sys); #1; cyc++;
      chk({tag, "_valid_cycle2"}, dsp.dout_valid, 0);
      @(posedge clk_sys); #1; cyc++;
      chk({tag, "_valid_cycle3"}, dsp.dout_valid, 1);
    end
    budget = n * 8 + 60;
    while (!done && cyc < budget) begin
      if (mid) begin
        start  = (cyc == 10);
        acqnum = 12'd5;
      end
      @(posedge clk_sys); #1; cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, done, 1);
    if (n == 0) chk({tag, "_done_latency"}, cyc, 2);
    if (mode == 0 && n > 0) chk({tag, "_throughput"}, (cyc <= n + 6), 1);
    s24 = 24'(exp_sum);
    chk({tag, "_sum"}, sum, s24);
`ifdef NOISE_SUMSQ_EN
    chk({tag, "_sumsq"}, sumsq, exp_sumsq);
`endif
    chk({tag, "_left_in_queue"}, exp_q.size(), 0);
    chk({tag, "_reads"}, reads, n);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk_sys); #1;
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_sum_held"}, sum, s24);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_n_rd_en"}, n_rd_en, 0);
    chk({tag, "_dout"}, dsp.dout, 0);
    chk({tag, "_dout_valid"}, dsp.dout_valid, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_sumsq"}, sumsq, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int k;
    reset  = 1'b1;
    start  = 1'b0;
    acqnum = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk_reset_values("rst");
    reset = 1'b0;

    run_record("fixed4", 4, 0, 0, 1'b0);
    run_record("toggle8", 8, 2, 1, 1'b0);
    run_record("zero", 0, 2, 0, 1'b0);
    for (int i = 0; i < 4; i++) run_record("rand", int'($urandom_range(1, 40)), 2, 2, 1'b0);
    run_record("full", 4095, 1, 0, 1'b0);
    run_record("midstart", 20, 2, 2, 1'b1);

    // Abort after three accepted samples of a 10-sample record.
    load_record(10, 2);
    ready_mode = 0;
    pulse_start(10);
    k = 0;
    while (accepts < 3 && k < 50) begin
      @(posedge clk_sys); #1; k++;
    end
    chk("abort_three_accepted", (accepts >= 3), 1);
    reset = 1'b1;
    #1;
    chk_reset_values("abort");
    @(posedge clk_sys); #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(posedge clk_sys); #1;
      chk("abort_no_done", done, 0);
      chk("abort_no_read", n_rd_en, 0);
    end
    run_record("after_abort", 2, 2, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
